// File: rtl/cpu_run_sequencer_if.sv
// Program-load stream and instruction-memory write port between host and run sequencer.
interface cpu_run_sequencer_if #(
  parameter int ADDR_W = 6
);
  logic              ld_valid;
  logic [31:0]       ld_data;
  logic              ld_last;
  logic              ld_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    output ld_valid, ld_data, ld_last,
    input  ld_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    input  ld_valid, ld_data, ld_last,
    output ld_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/cpu_run_sequencer.sv
// Run controller for the single-cycle core: loads imem, holds the core in reset,
// releases it, then watches for halt or cycle-budget timeout.
//
// state    | meaning
// st_idle  | waiting for start
// st_load  | accepting program words into imem
// st_hold  | core reset held RST_HOLD cycles after load
// st_run   | core released, counting cycles
// st_done  | results valid, core back in reset
module cpu_run_sequencer #(
  parameter int          ADDR_W     = 6,
  parameter int          MAX_WORDS  = 64,
  parameter int          CYC_W      = 16,
  parameter int          RST_HOLD   = 2,
  parameter logic [31:0] HALT_INSTR = 32'hFFFFFFFF
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 start,
  cpu_run_sequencer_if.slave   ld,
  output logic                 core_rst,
  input  logic [31:0]          core_instr,
  input  logic [31:0]          core_wd3,
  input  logic [CYC_W-1:0]     cycle_budget,
  output logic [CYC_W-1:0]     run_cycles,
  output logic [31:0]          last_wd3,
  output logic                 busy,
  output logic                 done,
  output logic                 error
);

  localparam int                HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(RST_HOLD - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MAX_WORDS - 1);

  typedef enum logic [2:0] {
    st_idle,
    st_load,
    st_hold,
    st_run,
    st_done
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] word_cnt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [CYC_W-1:0]  run_inc;

  assign run_inc = run_cycles + CYC_W'(1);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state         <= st_idle;
      word_cnt      <= '0;
      hold_cnt      <= '0;
      ld.imem_we    <= 1'b0;
      ld.imem_addr  <= '0;
      ld.imem_wdata <= '0;
      run_cycles    <= '0;
      last_wd3      <= '0;
      error         <= 1'b0;
    end else begin
      ld.imem_we <= 1'b0;
      case (state)
        st_idle, st_done: begin
          if (start) begin
            state      <= st_load;
            word_cnt   <= '0;
            run_cycles <= '0;
            last_wd3   <= '0;
            error      <= 1'b0;
          end
        end
        st_load: begin
          if (ld.ld_valid) begin
            ld.imem_we    <= 1'b1;
            ld.imem_addr  <= word_cnt;
            ld.imem_wdata <= ld.ld_data;
            word_cnt      <= word_cnt + ADDR_W'(1);
            // ld_last on the final slot is a legal full program, not an overflow
            if (ld.ld_last) begin
              state    <= st_hold;
              hold_cnt <= HOLD_LOAD;
            end else if (word_cnt == LAST_ADDR) begin
              state <= st_done;
              error <= 1'b1;
            end
          end
        end
        st_hold: begin
          if (hold_cnt == '0) state <= st_run;
          else                hold_cnt <= hold_cnt - HOLD_W'(1);
        end
        st_run: begin
          if (run_cycles != '1) run_cycles <= run_inc;
          last_wd3 <= core_wd3;
          // halt has priority over a timeout landing in the same cycle
          if (core_instr == HALT_INSTR) begin
            state <= st_done;
            error <= 1'b0;
          end else if ((cycle_budget != '0) && (run_inc == cycle_budget)) begin
            state <= st_done;
            error <= 1'b1;
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

  assign ld.ld_ready = (state == st_load);
  assign core_rst    = (state != st_run);
  assign busy        = (state == st_load) || (state == st_hold) || (state == st_run);
  assign done        = (state == st_done);

endmodule

// File: tb/tb_cpu_run_sequencer.sv
// Self-checking bench for cpu_run_sequencer: scoreboarded imem writes plus
// per-scenario checks of hold, run, timeout, overflow and reset behaviour.
module tb_cpu_run_sequencer;
  localparam int          ADDR_W   = 6;
  localparam int          MAXW     = 4;
  localparam int          CYC_W    = 16;
  localparam int          RST_HOLD = 2;
  localparam logic [31:0] HALT     = 32'hFFFFFFFF;

  logic              CLK;
  logic              RST;
  logic              start;
  logic              core_rst;
  logic [31:0]       core_instr;
  logic [31:0]       core_wd3;
  logic [CYC_W-1:0]  cycle_budget;
  logic [CYC_W-1:0]  run_cycles;
  logic [31:0]       last_wd3;
  logic              busy;
  logic              done;
  logic              error;

  cpu_run_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  cpu_run_sequencer #(
    .ADDR_W(ADDR_W), .MAX_WORDS(MAXW), .CYC_W(CYC_W),
    .RST_HOLD(RST_HOLD), .HALT_INSTR(HALT)
  ) dut (
    .CLK(CLK), .RST(RST), .start(start), .ld(bus),
    .core_rst(core_rst), .core_instr(core_instr), .core_wd3(core_wd3),
    .cycle_budget(cycle_budget), .run_cycles(run_cycles), .last_wd3(last_wd3),
    .busy(busy), .done(done), .error(error)
  );

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
    int                due;
  } wr_t;

  wr_t sb[$];
  wr_t mon_e;
  int  checks   = 0;
  int  failures = 0;
  int  cyc      = 0;
  int  exp_addr = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc = cyc + 1;

  // every imem write must match the oldest expected write, in the expected cycle
  always @(negedge CLK) begin
    if (bus.imem_we === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_write addr=%0d data=%h cyc=%0d", bus.imem_addr, bus.imem_wdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        if (bus.imem_addr !== mon_e.addr || bus.imem_wdata !== mon_e.data || cyc != mon_e.due) begin
          failures++;
          $display("FAIL imem_write got addr=%0d data=%h cyc=%0d exp addr=%0d data=%h cyc=%0d",
                   bus.imem_addr, bus.imem_wdata, cyc, mon_e.addr, mon_e.data, mon_e.due);
        end
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic start_load();
    start    = 1'b1;
    exp_addr = 0;
    tick();
    start = 1'b0;
    checks++;
    if ({bus.ld_ready, busy, done, core_rst} !== 4'b1101) begin
      failures++;
      $display("FAIL enter_load got ready/busy/done/core_rst=%b exp 1101",
               {bus.ld_ready, busy, done, core_rst});
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = d;
    bus.ld_last  = last;
    checks++;
    if (bus.ld_ready !== 1'b1) begin
      failures++;
      $display("FAIL ld_ready got %b exp 1", bus.ld_ready);
    end
    sb.push_back('{ADDR_W'(exp_addr), d, cyc + 1});
    exp_addr++;
    tick();
  endtask

  task automatic idle_word();
    bus.ld_valid = 1'b0;
    tick();
  endtask

  task automatic enter_run();
    int n;
    bus.ld_valid = 1'b0;
    n = 0;
    while (core_rst !== 1'b0 && n < 20) begin
      tick();
      n++;
    end
    checks++;
    if (n != RST_HOLD) begin
      failures++;
      $display("FAIL hold_cycles got %0d exp %0d", n, RST_HOLD);
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL writes_outstanding got %0d exp 0", sb.size());
    end
  endtask

  task automatic do_run(input int halt_at, input logic [31:0] halt_wd3,
                        input logic [CYC_W-1:0] budget, input int exp_cycles,
                        input logic exp_err);
    int k;
    logic [31:0] exp_wd3;
    cycle_budget = budget;
    k = 0;
    exp_wd3 = 32'h0;
    while (done !== 1'b1 && k < 40) begin
      k++;
      core_instr = (k == halt_at) ? HALT : 32'h00000013;
      core_wd3   = (k == halt_at) ? halt_wd3 : (32'h1000 + 32'(k));
      exp_wd3    = core_wd3;
      tick();
    end
    core_instr = 32'h0;
    checks++;
    if (k != exp_cycles) begin
      failures++;
      $display("FAIL run_length got %0d exp %0d", k, exp_cycles);
    end
    checks++;
    if ({done, error, core_rst, busy} !== {1'b1, exp_err, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL run_end done/error/core_rst/busy got %b exp %b",
               {done, error, core_rst, busy}, {1'b1, exp_err, 1'b1, 1'b0});
    end
    checks++;
    if (run_cycles !== CYC_W'(exp_cycles)) begin
      failures++;
      $display("FAIL run_cycles got %0d exp %0d", run_cycles, exp_cycles);
    end
    checks++;
    if (last_wd3 !== exp_wd3) begin
      failures++;
      $display("FAIL last_wd3 got %h exp %h", last_wd3, exp_wd3);
    end
  endtask

  task automatic test_reset();
    RST          = 1'b1;
    start        = 1'b1;
    bus.ld_valid = 1'b1;
    bus.ld_data  = 32'hDEADBEEF;
    bus.ld_last  = 1'b0;
    core_instr   = 32'h0;
    core_wd3     = 32'h0;
    cycle_budget = '0;
    tick();
    tick();
    checks++;
    if ({bus.ld_ready, busy, done, error, core_rst} !== 5'b00001) begin
      failures++;
      $display("FAIL reset_flags ready/busy/done/error/core_rst got %b exp 00001",
               {bus.ld_ready, busy, done, error, core_rst});
    end
    checks++;
    if ({bus.imem_we, bus.imem_addr, bus.imem_wdata} !== '0) begin
      failures++;
      $display("FAIL reset_imem we=%b addr=%0d data=%h exp all zero",
               bus.imem_we, bus.imem_addr, bus.imem_wdata);
    end
    checks++;
    if (run_cycles !== '0 || last_wd3 !== '0) begin
      failures++;
      $display("FAIL reset_results run_cycles=%0d last_wd3=%h exp 0/0", run_cycles, last_wd3);
    end
    RST          = 1'b0;
    start        = 1'b0;
    bus.ld_valid = 1'b0;
    tick();
    checks++;
    if ({bus.ld_ready, busy, core_rst} !== 3'b001) begin
      failures++;
      $display("FAIL idle_after_reset ready/busy/core_rst got %b exp 001",
               {bus.ld_ready, busy, core_rst});
    end
  endtask

  task automatic test_normal_run();
    start_load();
    send_word(32'h20100005, 1'b0);
    send_word(32'h20110007, 1'b0);
    send_word(32'hFFFFFFFF, 1'b1);
    enter_run();
    do_run(5, 32'h0000000C, '0, 5, 1'b0);
  endtask

  task automatic test_timeout();
    start_load();
    send_word(32'h20100005, 1'b1);
    enter_run();
    do_run(0, 32'h0, CYC_W'(4), 4, 1'b1);
    // stray words in DONE must not reach imem or disturb results
    bus.ld_valid = 1'b1;
    tick();
    tick();
    bus.ld_valid = 1'b0;
    checks++;
    if ({done, error} !== 2'b11 || run_cycles !== CYC_W'(4)) begin
      failures++;
      $display("FAIL done_hold done/error=%b run_cycles=%0d exp 11/4", {done, error}, run_cycles);
    end
    start_load();
    send_word(32'h20120001, 1'b1);
    enter_run();
    do_run(4, 32'h00000055, CYC_W'(4), 4, 1'b0);
  endtask

  task automatic test_overflow();
    bit rst_dropped;
    start_load();
    for (int i = 0; i < MAXW; i++) send_word(32'hA0000000 + 32'(i), 1'b0);
    bus.ld_valid = 1'b0;
    checks++;
    if ({done, error, core_rst, bus.ld_ready} !== 4'b1110) begin
      failures++;
      $display("FAIL overflow_end done/error/core_rst/ready got %b exp 1110",
               {done, error, core_rst, bus.ld_ready});
    end
    rst_dropped = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (core_rst !== 1'b1) rst_dropped = 1'b1;
    end
    checks++;
    if (rst_dropped || sb.size() != 0) begin
      failures++;
      $display("FAIL overflow_core_rst dropped=%b outstanding=%0d exp 0/0", rst_dropped, sb.size());
    end
  endtask

  task automatic test_backpressure();
    start_load();
    send_word(32'h11111111, 1'b0);
    idle_word();
    idle_word();
    send_word(32'h22222222, 1'b0);
    send_word(32'h33333333, 1'b1);
    enter_run();
  endtask

  task automatic test_midrun_reset();
    core_instr = 32'h00000013;
    core_wd3   = 32'h00000077;
    tick();
    tick();
    checks++;
    if (run_cycles !== CYC_W'(2) || last_wd3 !== 32'h77) begin
      failures++;
      $display("FAIL midrun_progress run_cycles=%0d last_wd3=%h exp 2/00000077", run_cycles, last_wd3);
    end
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if ({bus.ld_ready, busy, done, error, core_rst} !== 5'b00001 ||
        run_cycles !== '0 || last_wd3 !== '0) begin
      failures++;
      $display("FAIL midrun_reset flags=%b run_cycles=%0d last_wd3=%h exp 00001/0/0",
               {bus.ld_ready, busy, done, error, core_rst}, run_cycles, last_wd3);
    end
    core_instr = 32'h0;
    start_load();
    send_word(32'h2012000A, 1'b1);
    enter_run();
    do_run(1, 32'h0000000A, '0, 1, 1'b0);
  endtask

  initial begin
    test_reset();
    test_normal_run();
    test_timeout();
    test_overflow();
    test_backpressure();
    test_midrun_reset();
    tick();
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL final_outstanding got %0d exp 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cpu_run_sequencer.md
Name: cpu_run_sequencer

Overview:
- Run controller for the single-cycle processor core.
- Loads a program into instruction memory through a valid/ready stream, holds the core in reset, then releases it.
- While the core runs, counts cycles, detects a halt instruction or a cycle-budget timeout, and captures the last register-file write data (WD3).
- Sits between the test/host interface and the core's reset and imem write port.

Parameters:
ADDR_W, 6, imem word-address width
MAX_WORDS, 64, program capacity in words (≤ 2^ADDR_W)
CYC_W, 16, cycle counter width
RST_HOLD, 2, cycles core_rst is held high between load end and run start (≥1)
HALT_INSTR, 32'hFFFFFFFF, instruction word that terminates a run

Ports:
CLK  in  1  clock; all logic on rising edge
RST  in  1  synchronous active-high reset
start  in  1  pulse; begins LOAD from IDLE or DONE
ld_valid  in  1  program word valid
ld_data  in  32  program word
ld_last  in  1  marks final program word
ld_ready  out  1  sequencer accepts a word
imem_we  out  1  imem write strobe
imem_addr  out  ADDR_W  imem write address
imem_wdata  out  32  imem write data
core_rst  out  1  reset to core, active-high
core_instr  in  32  instruction currently fetched by core
core_wd3  in  32  core register-file write data (WD3)
cycle_budget  in  CYC_W  maximum run cycles; 0 = unlimited
run_cycles  out  CYC_W  cycles spent in RUN
last_wd3  out  32  core_wd3 sampled in the final RUN cycle
busy  out  1  state is LOAD, HOLD or RUN
done  out  1  run finished; results valid
error  out  1  set with done on overflow or timeout

Behaviour:
- States: IDLE, LOAD, HOLD, RUN, DONE. State is registered; ld_ready = (state==LOAD), core_rst = (state!=RUN), busy = (state in LOAD/HOLD/RUN). These outputs are decoded from the registered state only.
- Reset (RST=1 at an edge, from any state, including mid-load or mid-run):
  - state=IDLE.
  - imem_we=0, imem_addr=0, imem_wdata=0, run_cycles=0, last_wd3=0, done=0, error=0.
  - ld_ready=0, core_rst=1, busy=0.
- IDLE: start=1 → LOAD. On that edge: word counter=0, run_cycles=0, last_wd3=0, done=0, error=0.
- LOAD:
  - A handshake is ld_valid & ld_ready.
  - On a handshake: next cycle imem_we=1, imem_addr=word counter, imem_wdata=ld_data; word counter increments. imem_we is 0 in every other cycle (1-cycle registered latency).
  - Handshake with ld_last=1 → HOLD (write still issued).
  - Handshake with ld_last=0 at counter=MAX_WORDS-1 → the word is written, then → DONE with error=1, done=1. The core is never released.
  - ld_valid=0 → stay in LOAD with no write. No load timeout.
- HOLD: core_rst=1 for exactly RST_HOLD cycles (internal counter), then → RUN.
- RUN (core_rst=0); at each edge:
  - run_cycles += 1; last_wd3 <= core_wd3.
  - If core_instr==HALT_INSTR → DONE, error=0.
  - Else if cycle_budget!=0 and run_cycles+1==cycle_budget → DONE, error=1.
  - Halt and timeout in the same cycle: halt wins, error=0.
  - The final increment and sample are included, so run_cycles equals the number of RUN cycles.
  - run_cycles saturates at all-ones when cycle_budget=0.
- DONE: done=1, core_rst=1. run_cycles, last_wd3 and error are held. start=1 → LOAD (clears as in IDLE).
- start is ignored in LOAD, HOLD and RUN. ld_valid is ignored outside LOAD (ld_ready=0, no write).

Test Plan:
- Reset check: hold RST 2 cycles with start=1 and ld_valid=1 → all outputs at reset values, core_rst=1, no imem_we.
- Normal run: start; stream words 0x20100005, 0x20110007, 0xFFFFFFFF (last) with ld_valid held high.
  - Required: imem_we pulses at addr 0,1,2 with matching data, one cycle after each handshake.
  - Required: core_rst drops after 2 HOLD cycles.
  - Stub drives core_instr=0xFFFFFFFF on the 5th RUN cycle with core_wd3=0x0000000C → done=1, error=0, run_cycles=5, last_wd3=0x0000000C.
- Timeout: cycle_budget=4, halt never fetched → done=1, error=1, run_cycles=4 after exactly 4 RUN cycles. Repeat with halt on the 4th cycle → error=0, run_cycles=4.
- Overflow: MAX_WORDS=4; send 4 words with ld_last=0 → 4 writes at addr 0..3, done=1, error=1, core_rst never low.
- Backpressure/gaps: ld_valid toggling 1,0,0,1,1 → writes only on handshake cycles, contiguous addresses 0,1,2.
- Mid-run reset and restart: RST asserted in RUN cycle 3 → next edge IDLE, run_cycles=0, core_rst=1. Then start again → a fresh load succeeds from addr 0.
